// File: rtl/writeback_unit_if.sv
// writeback_unit_if: execute/memory/register-file bundle; instruction class codes; WB_FWD_EN adds forwarding signals
`ifndef WB_ITYPE_CODES
`define WB_ITYPE_CODES
`define RTYPE  5'b01100
`define ITYPE  5'b00100
`define STYPE  5'b01000
`define BTYPE  5'b11000
`define LTYPE  5'b00000
`define UTYPE  5'b01101
`define JTYPE  5'b11011
`define JRTYPE 5'b11001
`endif

interface writeback_unit_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [4:0]  itype_i;
  logic [4:0]  rd_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_i;
  logic [31:0] pc_i;
  logic        mem_valid_i;
  logic [31:0] mem_data_i;
  logic [31:0] wd_o;
  logic        wd_q_o;
  logic [4:0]  wd_rd_o;
  logic        err_o;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_rs_i;
  logic        fwd_hit_o;
  logic [31:0] fwd_data_o;
`endif
  modport slave (
    input  in_valid_i, itype_i, rd_i, funct3_i, alu_i, pc_i, mem_valid_i, mem_data_i,
`ifdef WB_FWD_EN
    input  fwd_rs_i,
    output fwd_hit_o, fwd_data_o,
`endif
    output in_ready_o, wd_o, wd_q_o, wd_rd_o, err_o
  );
  modport master (
    output in_valid_i, itype_i, rd_i, funct3_i, alu_i, pc_i, mem_valid_i, mem_data_i,
`ifdef WB_FWD_EN
    output fwd_rs_i,
    input  fwd_hit_o, fwd_data_o,
`endif
    input  in_ready_o, wd_o, wd_q_o, wd_rd_o, err_o
  );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: formats completed instructions and drives the register-file write port with a one-cycle strobe.
// Optional WB_FWD_EN exposes the committing result as a forwarding path.
module writeback_unit #(
  parameter int unsigned LOAD_TIMEOUT = 255
) (
  input logic             clk,
  input logic             reset,
  writeback_unit_if.slave bus
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD_WAIT = 2'd1;
  localparam logic [1:0] COMMIT    = 2'd2;
  localparam int unsigned CW = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    rd_q, rd_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [4:0]    wrd_q, wrd_d;
  logic          err_q, err_d;
  logic          alu_class;
  logic [31:0]   alu_res;
  logic [31:0]   load_res;

  function automatic logic [31:0] load_fmt(logic [2:0] f3, logic [1:0] a, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    return f3 == 3'b000 ? {{24{b[7]}}, b} :
           f3 == 3'b001 ? {{16{h[15]}}, h} :
           f3 == 3'b100 ? {24'h0, b} :
           f3 == 3'b101 ? {16'h0, h} : w;
  endfunction

  always_comb begin
    alu_class = bus.itype_i == `RTYPE || bus.itype_i == `ITYPE || bus.itype_i == `UTYPE ||
                bus.itype_i == `JTYPE || bus.itype_i == `JRTYPE;
    alu_res   = bus.itype_i == `UTYPE ? {bus.alu_i[19:0], 12'h000} :
                (bus.itype_i == `JTYPE || bus.itype_i == `JRTYPE) ? bus.pc_i + 32'd4 : bus.alu_i;
    load_res  = load_fmt(f3_q, lane_q, bus.mem_data_i);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    wrd_d   = wrd_q;
    err_d   = err_q;
    if (state_q == IDLE) begin
      if (bus.in_valid_i && bus.itype_i == `LTYPE) begin
        state_d = LOAD_WAIT;
        cnt_d   = '0;
        rd_d    = bus.rd_i;
        f3_d    = bus.funct3_i;
        lane_d  = bus.alu_i[1:0];
      end else if (bus.in_valid_i && alu_class && bus.rd_i != 5'd0) begin
        state_d = COMMIT;
        wdata_d = alu_res;
        wrd_d   = bus.rd_i;
      end
    end else if (state_q == LOAD_WAIT) begin
      if (bus.mem_valid_i) begin
        state_d = rd_q != 5'd0 ? COMMIT : IDLE;
        wdata_d = rd_q != 5'd0 ? load_res : wdata_q;
        wrd_d   = rd_q != 5'd0 ? rd_q : wrd_q;
      end else if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
      wrd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      wrd_q   <= wrd_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready_o = state_q == IDLE;
  assign bus.wd_q_o     = state_q == COMMIT;
  assign bus.wd_o       = wdata_q;
  assign bus.wd_rd_o    = wrd_q;
  assign bus.err_o      = err_q;
`ifdef WB_FWD_EN
  assign bus.fwd_hit_o  = state_q == COMMIT && bus.fwd_rs_i != 5'd0 && bus.fwd_rs_i == wrd_q;
  assign bus.fwd_data_o = bus.fwd_hit_o ? wdata_q : 32'h0;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: vector table plus hand sequences; write-port strobes checked against a scoreboard queue.
module tb_writeback_unit;
  typedef struct {
    logic [4:0]  itype;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] mem;
    logic        wr;
    logic [31:0] exp;
  } vec_t;
  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  writeback_unit_if bus();
  writeback_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int ncmp = 0;
  int nbad = 0;
  logic prev_q = 1'b0;
  logic [31:0] last_wd = 32'h0;
  wr_t sb[$];
  vec_t v[17];

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (bus.wd_q_o && prev_q) begin
      ncmp++;
      nbad++;
      $display("FAIL strobe_width: wd_q_o high two cycles running at %0t", $time);
    end else if (bus.wd_q_o) begin
      if (sb.size() == 0) begin
        ncmp++;
        nbad++;
        $display("FAIL unexpected_strobe: got write rd=%0d data=%h expected none at %0t", bus.wd_rd_o, bus.wd_o, $time);
      end else begin
        e = sb.pop_front();
        check("wd_data", bus.wd_o, e.d);
        check("wd_rd", 32'(bus.wd_rd_o), 32'(e.rd));
      end
    end
    prev_q = bus.wd_q_o;
  endtask

  task automatic drive(input logic [4:0] it, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc);
    bus.in_valid_i = 1'b1;
    bus.itype_i    = it;
    bus.rd_i       = rd;
    bus.funct3_i   = f3;
    bus.alu_i      = alu;
    bus.pc_i       = pc;
  endtask

  task automatic run_vec(input vec_t t);
    check("ready_idle", 32'(bus.in_ready_o), 32'd1);
    drive(t.itype, t.rd, t.f3, t.alu, t.pc);
    if (t.wr) sb.push_back('{t.exp, t.rd});
    tick();
    bus.in_valid_i = 1'b0;
    if (t.itype == `LTYPE) begin
      check("load_wait_ready", 32'(bus.in_ready_o), 32'd0);
      check("load_wait_nostrobe", 32'(bus.wd_q_o), 32'd0);
      repeat (3) tick();
      bus.mem_valid_i = 1'b1;
      bus.mem_data_i  = t.mem;
      tick();
      bus.mem_valid_i = 1'b0;
      bus.mem_data_i  = 32'hDEAD_0000;
    end
    check("strobe_latency", 32'(bus.wd_q_o), 32'(t.wr));
    check("ready_after", 32'(bus.in_ready_o), 32'(!t.wr));
    if (!t.wr) check("wd_held", bus.wd_o, last_wd);
    else last_wd = t.exp;
    tick();
    check("strobe_low", 32'(bus.wd_q_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    v[0]  = '{`ITYPE,  5'd5,  3'd0, 32'h0000_0007, 32'h0,         32'h0,         1'b1, 32'h0000_0007};
    v[1]  = '{`LTYPE,  5'd3,  3'd0, 32'h0000_1002, 32'h0,         32'h0080_0000, 1'b1, 32'hFFFF_FF80};
    v[2]  = '{`LTYPE,  5'd4,  3'd5, 32'h0000_0002, 32'h0,         32'hA1B2_C3D4, 1'b1, 32'h0000_A1B2};
    v[3]  = '{`LTYPE,  5'd6,  3'd2, 32'h0000_0000, 32'h0,         32'hA1B2_C3D4, 1'b1, 32'hA1B2_C3D4};
    v[4]  = '{`LTYPE,  5'd7,  3'd4, 32'h0000_0001, 32'h0,         32'hA1B2_C3D4, 1'b1, 32'h0000_00C3};
    v[5]  = '{`LTYPE,  5'd8,  3'd1, 32'h0000_0003, 32'h0,         32'h8001_1234, 1'b1, 32'hFFFF_8001};
    v[6]  = '{`JTYPE,  5'd1,  3'd0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000};
    v[7]  = '{`UTYPE,  5'd2,  3'd0, 32'hFFF1_2345, 32'h0,         32'h0,         1'b1, 32'h1234_5000};
    v[8]  = '{`RTYPE,  5'd9,  3'd0, 32'hDEAD_BEEF, 32'h0,         32'h0,         1'b1, 32'hDEAD_BEEF};
    v[9]  = '{`JRTYPE, 5'd31, 3'd0, 32'h0000_0040, 32'h0000_0100, 32'h0,         1'b1, 32'h0000_0104};
    v[10] = '{`ITYPE,  5'd0,  3'd0, 32'h0000_0099, 32'h0,         32'h0,         1'b0, 32'h0};
    v[11] = '{`STYPE,  5'd5,  3'd2, 32'h0000_0011, 32'h0,         32'h0,         1'b0, 32'h0};
    v[12] = '{`BTYPE,  5'd5,  3'd0, 32'h0000_0022, 32'h0,         32'h0,         1'b0, 32'h0};
    v[13] = '{5'b11111,5'd5,  3'd0, 32'h0000_0033, 32'h0,         32'h0,         1'b0, 32'h0};
    v[14] = '{`LTYPE,  5'd0,  3'd2, 32'h0000_0000, 32'h0,         32'h5555_AAAA, 1'b0, 32'h0};
    v[15] = '{`LTYPE,  5'd11, 3'd0, 32'h0000_0003, 32'h0,         32'h7F00_0000, 1'b1, 32'h0000_007F};
    v[16] = '{`LTYPE,  5'd10, 3'd3, 32'h0000_0001, 32'h0,         32'h1234_5678, 1'b1, 32'h1234_5678};
    bus.in_valid_i  = 1'b0;
    bus.itype_i     = '0;
    bus.rd_i        = '0;
    bus.funct3_i    = '0;
    bus.alu_i       = '0;
    bus.pc_i        = '0;
    bus.mem_valid_i = 1'b0;
    bus.mem_data_i  = '0;
`ifdef WB_FWD_EN
    bus.fwd_rs_i    = '0;
`endif
    repeat (3) tick();
    reset = 1'b0;
    check("rst_ready", 32'(bus.in_ready_o), 32'd1);
    check("rst_wd_q", 32'(bus.wd_q_o), 32'd0);
    check("rst_wd", bus.wd_o, 32'h0);
    check("rst_wd_rd", 32'(bus.wd_rd_o), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    for (int i = 0; i < 17; i++) run_vec(v[i]);
    // back-to-back ALU ops: second request held during COMMIT must wait for IDLE
    drive(`RTYPE, 5'd20, 3'd0, 32'h0000_0011, 32'h0);
    sb.push_back('{32'h0000_0011, 5'd20});
    tick();
    check("b2b_first", 32'(bus.wd_q_o), 32'd1);
    check("b2b_busy", 32'(bus.in_ready_o), 32'd0);
    drive(`RTYPE, 5'd21, 3'd0, 32'h0000_0022, 32'h0);
    sb.push_back('{32'h0000_0022, 5'd21});
    tick();
    check("b2b_gap", 32'(bus.wd_q_o), 32'd0);
    tick();
    bus.in_valid_i = 1'b0;
    check("b2b_second", 32'(bus.wd_q_o), 32'd1);
    tick();
    check("b2b_low", 32'(bus.wd_q_o), 32'd0);
    last_wd = 32'h0000_0022;
    bus.mem_valid_i = 1'b1;
    bus.mem_data_i  = 32'hCAFE_F00D;
    tick();
    bus.mem_valid_i = 1'b0;
    check("stray_mem_nostrobe", 32'(bus.wd_q_o), 32'd0);
    check("stray_mem_ready", 32'(bus.in_ready_o), 32'd1);
    check("stray_mem_held", bus.wd_o, last_wd);
    drive(`LTYPE, 5'd12, 3'd2, 32'h0, 32'h0);
    tick();
    bus.in_valid_i = 1'b0;
    repeat (254) tick();
    check("timeout_not_yet", 32'(bus.err_o), 32'd0);
    check("timeout_waiting", 32'(bus.in_ready_o), 32'd0);
    tick();
    check("timeout_err", 32'(bus.err_o), 32'd1);
    check("timeout_idle", 32'(bus.in_ready_o), 32'd1);
    check("timeout_nostrobe", 32'(bus.wd_q_o), 32'd0);
    check("timeout_held", bus.wd_o, last_wd);
    run_vec('{`ITYPE, 5'd15, 3'd0, 32'h0000_0055, 32'h0, 32'h0, 1'b1, 32'h0000_0055});
    check("err_sticky", 32'(bus.err_o), 32'd1);
    drive(`LTYPE, 5'd13, 3'd2, 32'h0, 32'h0);
    tick();
    bus.in_valid_i = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_lw_ready", 32'(bus.in_ready_o), 32'd1);
    check("rst_lw_err", 32'(bus.err_o), 32'd0);
    check("rst_lw_wd", bus.wd_o, 32'h0);
    check("rst_lw_wd_rd", 32'(bus.wd_rd_o), 32'd0);
    bus.mem_valid_i = 1'b1;
    bus.mem_data_i  = 32'h1111_2222;
    tick();
    bus.mem_valid_i = 1'b0;
    check("rst_lw_nostrobe", 32'(bus.wd_q_o), 32'd0);
    tick();
    check("rst_lw_nostrobe2", 32'(bus.wd_q_o), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
